// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: N_CH producer channels in, one registered
// output channel plus a completed-transfer counter.
interface rr_mux_arb_if #(
  parameter int N_CH = 8,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH),
  parameter int CNTW = 16
);
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N_CH*DW-1:0]   in_data;
  logic [N_CH-1:0]      in_valid;
  logic [N_CH-1:0]      in_ready;
  logic [DW-1:0]        out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNTW-1:0]      xfer_cnt;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, xfer_cnt
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, xfer_cnt
  );
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel registered mux with round-robin or fixed-select arbitration into a
// single-entry output register tagged with the source channel index.
module rr_mux_arb #(
  parameter int N_CH = 8,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH),
  parameter int CNTW = 16
) (
  input logic        clk,
  input logic        rst_n,
  rr_mux_arb_if.slave bus
);
  localparam int PW = $clog2(N_CH);

  logic [N_CH-1:0][DW-1:0] w_lane;
  logic [PW-1:0]           r_ptr;
  logic [DW-1:0]           r_data;
  logic [SELW-1:0]         r_ch;
  logic                    r_valid;
  logic [CNTW-1:0]         r_cnt;

  logic                    w_load;
  logic                    w_hi_any, w_lo_any, w_any;
  logic [PW-1:0]           w_hi_idx, w_lo_idx, w_idx;

  assign w_lane = bus.in_data;
  assign w_load = !r_valid || bus.out_ready;

  // Rotated search as two linear scans: lowest requester at/above ptr wins,
  // otherwise the lowest requester overall (the wrapped part of the order).
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.in_valid[k] && !w_lo_any) begin
        w_lo_any = 1'b1;
        w_lo_idx = PW'(k);
      end
      if (bus.in_valid[k] && (k >= int'(r_ptr)) && !w_hi_any) begin
        w_hi_any = 1'b1;
        w_hi_idx = PW'(k);
      end
    end
  end

  // Fixed select: an out-of-range sel matches no lane and so grants nothing.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    if (bus.mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (int'(bus.sel) == k) begin
          w_any = bus.in_valid[k];
          w_idx = PW'(k);
        end
      end
    end else if (w_hi_any) begin
      w_any = 1'b1;
      w_idx = w_hi_idx;
    end else begin
      w_any = w_lo_any;
      w_idx = w_lo_idx;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_rdy
    assign bus.in_ready[k] = rst_n && w_load && w_any && (w_idx == PW'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      if (r_valid && bus.out_ready) r_cnt <= r_cnt + CNTW'(1);
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_lane[w_idx];
          r_ch   <= SELW'(w_idx);
          if (!bus.mode) r_ptr <= (w_idx == PW'(N_CH-1)) ? '0 : w_idx + PW'(1);
        end
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.out_valid = r_valid;
  assign bus.xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: the stimulus side predicts each accepted word
// from the arbitration rules; a negedge monitor compares whatever the DUT shows.
module tb_rr_mux_arb;
  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int SELW = 4;  // wide enough to drive sel values >= N
  localparam int CNTW = 4;  // small so the counter wraps during the run

  typedef struct packed {
    logic [SELW-1:0] ch;
    logic [DW-1:0]   d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_arb_if #(.N_CH(N), .DW(DW), .SELW(SELW), .CNTW(CNTW)) bus ();
  rr_mux_arb #(.N_CH(N), .DW(DW), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  ent_t        exp_q[$];
  logic [N-1:0] exp_rdy = '0;
  int          pops = 0;
  int          m_ptr = 0;
  logic [DW-1:0] dat [N];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference arbitration: walk channels ptr, ptr+1, ... modulo N.
  function automatic int grant(int ptr, logic [N-1:0] v, bit md, int sl);
    if (md) return (sl < N && v[sl]) ? sl : -1;
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Called at posedge+2; returns at the next posedge+2.
  task automatic step(bit md, int sl, logic [N-1:0] v, bit ordy);
    bit   load;
    int   g;
    ent_t e;
    bus.mode      = md;
    bus.sel       = SELW'(sl);
    bus.in_valid  = v;
    bus.out_ready = ordy;
    for (int k = 0; k < N; k++) bus.in_data[k*DW +: DW] = dat[k];
    load = (exp_q.size() == 0) || ordy;
    g = grant(m_ptr, v, md, sl);
    exp_rdy = '0;
    if (load && g >= 0) begin
      exp_rdy[g] = 1'b1;
      e.ch = SELW'(g);
      e.d  = dat[g];
    end
    @(posedge clk);
    if (load && g >= 0) begin
      exp_q.push_back(e);
      if (!md) m_ptr = (g + 1) % N;
    end
    #2;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("xfer_cnt", 64'(bus.xfer_cnt), 64'(pops % (1 << CNTW)));
        if (exp_q.size() == 0) begin
          chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
        end else begin
          chk("out_valid", 64'(bus.out_valid), 64'd1);
          chk("out_data", 64'(bus.out_data), 64'(exp_q[0].d));
          chk("out_ch", 64'(bus.out_ch), 64'(exp_q[0].ch));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) dat[k] = DW'(k * 17);
    bus.mode = 1'b0;
    bus.sel = '0;
    bus.in_valid = '1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) bus.in_data[k*DW +: DW] = dat[k];

    // Reset held with every channel requesting
    #23;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("rst_xfer_cnt", 64'(bus.xfer_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Full round-robin, then one idle cycle to drain the ninth word
    step(0, 0, 8'hFF, 1);
    chk("rr_first_ch", 64'(bus.out_ch), 64'd0);
    for (int i = 1; i < 9; i++) step(0, 0, 8'hFF, 1);
    chk("rr_ninth_ch", 64'(bus.out_ch), 64'd0);
    step(0, 0, 8'h00, 1);
    chk("rr_xfer_cnt9", 64'(bus.xfer_cnt), 64'd9);
    chk("rr_idle_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure while channel 2 is held
    step(0, 0, 8'hFF, 1);
    step(0, 0, 8'hFF, 1);
    chk("bp_ch2", 64'(bus.out_ch), 64'd2);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'hFF, 0);
      chk("bp_hold_data", 64'(bus.out_data), 64'h22);
      chk("bp_hold_ch", 64'(bus.out_ch), 64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    step(0, 0, 8'hFF, 1);
    chk("bp_next_ch3", 64'(bus.out_ch), 64'd3);

    // Sparse wrap: 6, then only 7 and 1 requesting
    step(0, 0, 8'h40, 1);
    chk("wrap_ch6", 64'(bus.out_ch), 64'd6);
    step(0, 0, 8'h82, 1);
    chk("wrap_ch7", 64'(bus.out_ch), 64'd7);
    step(0, 0, 8'h82, 1);
    chk("wrap_ch1", 64'(bus.out_ch), 64'd1);

    // Fixed select
    for (int i = 0; i < 3; i++) begin
      step(1, 5, 8'h28, 1);
      chk("fix_in_ready", 64'(bus.in_ready), 64'h20);
      chk("fix_ch5", 64'(bus.out_ch), 64'd5);
    end
    step(1, 5, 8'h08, 1);
    chk("fix_drop_valid", 64'(bus.out_valid), 64'd0);
    step(1, 9, 8'hFF, 1);
    chk("fix_sel9_rdy", 64'(bus.in_ready), 64'd0);
    chk("fix_sel9_valid", 64'(bus.out_valid), 64'd0);

    // Async reset mid-burst, asserted between edges
    for (int i = 0; i < 4; i++) step(0, 0, 8'hFF, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    pops = 0;
    m_ptr = 0;
    exp_rdy = '0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(bus.xfer_cnt), 64'd0);
    chk("mid_rst_rdy", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(0, 0, 8'hFF, 1);
    chk("mid_rst_restart_ch", 64'(bus.out_ch), 64'd0);

    // Randomized traffic, mode and sel switching on any cycle
    for (int i = 0; i < 400; i++) begin
      bit   md;
      int   sl;
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) dat[k] = DW'($urandom);
      md = ($urandom_range(0, 3) == 0);
      sl = $urandom_range(0, 9);
      v  = N'($urandom) & N'($urandom);
      step(md, sl, v, $urandom_range(0, 9) < 7);
    end
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
